operand_issue_gate: RTL
=======================

Name: operand_issue_gate

Overview:
- Front-end issue gate feeding the register status scoreboard.
- Holds one decoded instruction and checks its operands against the scoreboard's Dirty/ToBeWritten/ToBeRead vectors.
- When hazard-free, it emits reservation pulses (ReadingFromA/B, WillBeWritingToA, MarkADirty) and moves the instruction into an output register.
- When the downstream stage accepts the instruction, it emits issue pulses (IssuedFromA/B) back to the scoreboard.
- Two registered stages, valid/ready on both sides.

Parameters:
STALL_CNT_W, 8, width of the saturating per-instruction stall counter

Ports:
clk  input  1  clock
async_rst_n  input  1  asynchronous active-low reset
clk_en  input  1  global clock enable; low freezes all state and forces pulses low
InstValid  input  1  upstream instruction valid
InstReady  output  1  gate can accept an instruction this cycle
InstReadA  input  1  instruction reads operand A
InstWriteA  input  1  instruction writes operand A
InstMarkDirty  input  1  write to A marks it dirty
InstAAddr  input  4  operand A register
InstReadB  input  1  instruction reads operand B
InstBAddr  input  4  operand B register
DirtyVector  input  16  scoreboard dirty bits
ToBeWrittenVector  input  16  scoreboard pending-write bits
ToBeReadVector  input  16  scoreboard pending-read bits
ReadingFromA  output  1  reservation pulse, A read
WillBeWritingToA  output  1  reservation pulse, A write
MarkADirty  output  1  reservation pulse, mark dirty
ReadAAddress  output  4  A address for reservation
ReadingFromB  output  1  reservation pulse, B read
ReadBAddress  output  4  B address for reservation
IssueValid  output  1  output register valid
IssueReady  input  1  downstream accepts
IssueReadA/IssueWriteA/IssueMarkDirty/IssueReadB  output  1 each  registered flags
IssueAAddr/IssueBAddr  output  4 each  registered addresses
IssuedFromA  output  1  issue pulse, A
IssueAAddress  output  4  A address of issued instruction
IssuedFromB  output  1  issue pulse, B
IssueBAddress  output  4  B address of issued instruction
HazardStall  output  1  held instruction blocked by a hazard
StallCycles  output  STALL_CNT_W  stall cycles of the current held instruction

Behaviour:
- Reset: HeldValid=0 and IssueValid=0. All held and output fields are 0. StallCycles=0. All pulses are 0.
- Hold stage:
  - Captures Inst* on InstValid && InstReady.
  - InstReady = !HeldValid || Advance.
- Hazard (combinational on the held instruction), Hazard = OR of:
  - HeldReadA && TBW[A]
  - HeldReadB && TBW[B]
  - HeldWriteA && (TBW[A] || TBR[A])
  - HeldWriteA && HeldMarkDirty && Dirty[A]
- Register 14 is treated like any other index; the vectors already carry the stack state.
- Advance = HeldValid && !Hazard && (!IssueValid || IssueReady).
- On Advance, in the same cycle (combinational, qualified by clk_en):
  - ReadingFromA = HeldReadA
  - WillBeWritingToA = HeldWriteA
  - MarkADirty = HeldWriteA && HeldMarkDirty
  - ReadingFromB = HeldReadB
  - ReadAAddress/ReadBAddress = held addresses
  - Addresses are don't-care when their pulse is low but must be driven to the held values.
- Output register:
  - Loads the held fields on Advance.
  - IssueValid clears on (IssueValid && IssueReady && !Advance).
- Issue pulses (combinational):
  - IssuedFromA = IssueValid && IssueReady && IssueReadA.
  - IssuedFromB likewise with IssueReadB.
  - Addresses come from the output register.
- Back-to-back throughput:
  - Issue handshake and Advance in the same cycle are allowed (output replaced).
  - Hold-stage load and Advance in the same cycle are allowed.
  - The scoreboard updates one cycle after the reservation, and a newly loaded instruction is first evaluated the cycle after capture, so no bypass is needed.
- Stall counter:
  - HazardStall = HeldValid && Hazard.
  - StallCycles increments while HazardStall, saturating at all-ones.
  - Resets to 0 when a new instruction is captured.
  - A full-output-register stall without a hazard does not count.
- clk_en=0: no state change; all reservation and issue pulses are 0; InstReady=0.
- Async reset mid-operation drops both stages immediately; no pulses are emitted.

Test Plan:
1. Reset, then InstValid with ReadA=1, A=3, ReadB=1, B=5, all vectors 0 → ReadingFromA/B pulse one cycle after capture with addresses 3/5; next cycle IssueValid=1; IssueReady=1 → IssuedFromA=1 with IssueAAddress=3, and IssuedFromB=1 with IssueBAddress=5.
2. Held instruction with ReadA=1, A=7 and TBW[7]=1 for 10 cycles → HazardStall=1, StallCycles reaches 10, no pulses, InstReady=0; TBW[7]→0 → Advance, StallCycles resets on the next capture.
3. Write-after-read: WriteA=1, A=2 while TBR[2]=1 → stalls; clearing TBR[2] → WillBeWritingToA=1 with ReadAAddress=2.
4. IssueReady=0 with IssueValid=1 and a hazard-free held instruction → no Advance, StallCycles stays 0; IssueReady=1 → issue pulse and Advance in the same cycle.
5. Hazard held for 300 cycles with STALL_CNT_W=8 → StallCycles saturates at 255.
6. Assert async_rst_n low mid-stall, and separately drop clk_en → all valids and pulses go to 0 immediately (reset), and state is frozen (clk_en=0).

Source files
------------

// File: rtl/operand_issue_gate.sv
// Two-stage operand issue gate: holds one decoded instruction, checks it against
// the register scoreboard, reserves its operands, then presents it downstream.
module operand_issue_gate #(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   async_rst_n,
  input  logic                   clk_en,
  input  logic                   InstValid,
  output logic                   InstReady,
  input  logic                   InstReadA,
  input  logic                   InstWriteA,
  input  logic                   InstMarkDirty,
  input  logic [3:0]             InstAAddr,
  input  logic                   InstReadB,
  input  logic [3:0]             InstBAddr,
  input  logic [15:0]            DirtyVector,
  input  logic [15:0]            ToBeWrittenVector,
  input  logic [15:0]            ToBeReadVector,
  output logic                   ReadingFromA,
  output logic                   WillBeWritingToA,
  output logic                   MarkADirty,
  output logic [3:0]             ReadAAddress,
  output logic                   ReadingFromB,
  output logic [3:0]             ReadBAddress,
  output logic                   IssueValid,
  input  logic                   IssueReady,
  output logic                   IssueReadA,
  output logic                   IssueWriteA,
  output logic                   IssueMarkDirty,
  output logic                   IssueReadB,
  output logic [3:0]             IssueAAddr,
  output logic [3:0]             IssueBAddr,
  output logic                   IssuedFromA,
  output logic [3:0]             IssueAAddress,
  output logic                   IssuedFromB,
  output logic [3:0]             IssueBAddress,
  output logic                   HazardStall,
  output logic [STALL_CNT_W-1:0] StallCycles
);

  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic       vld_p0;
  logic       readA_p0, writeA_p0, markDirty_p0, readB_p0;
  logic [3:0] aAddr_p0, bAddr_p0;
  logic       vld_p1;
  logic       readA_p1, writeA_p1, markDirty_p1, readB_p1;
  logic [3:0] aAddr_p1, bAddr_p1;

  logic hazard, advance, capture, issueFire;

  // Hold stage evaluation: scoreboard state already reflects last cycle's reservation
  always_comb begin
    hazard = (readA_p0 && ToBeWrittenVector[aAddr_p0])
          || (readB_p0 && ToBeWrittenVector[bAddr_p0])
          || (writeA_p0 && (ToBeWrittenVector[aAddr_p0] || ToBeReadVector[aAddr_p0]))
          || (writeA_p0 && markDirty_p0 && DirtyVector[aAddr_p0]);
  end

  assign advance   = clk_en && vld_p0 && !hazard && (!vld_p1 || IssueReady);
  assign InstReady = clk_en && (!vld_p0 || advance);
  assign capture   = InstValid && InstReady;
  assign issueFire = clk_en && vld_p1 && IssueReady;

  assign HazardStall      = vld_p0 && hazard;
  assign ReadingFromA     = advance && readA_p0;
  assign WillBeWritingToA = advance && writeA_p0;
  assign MarkADirty       = advance && writeA_p0 && markDirty_p0;
  assign ReadingFromB     = advance && readB_p0;
  assign ReadAAddress     = aAddr_p0;
  assign ReadBAddress     = bAddr_p0;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      vld_p0       <= 1'b0;
      readA_p0     <= 1'b0;
      writeA_p0    <= 1'b0;
      markDirty_p0 <= 1'b0;
      readB_p0     <= 1'b0;
      aAddr_p0     <= '0;
      bAddr_p0     <= '0;
      StallCycles  <= '0;
    end else if (capture) begin
      vld_p0       <= 1'b1;
      readA_p0     <= InstReadA;
      writeA_p0    <= InstWriteA;
      markDirty_p0 <= InstMarkDirty;
      readB_p0     <= InstReadB;
      aAddr_p0     <= InstAAddr;
      bAddr_p0     <= InstBAddr;
      StallCycles  <= '0;
    end else if (advance) begin
      vld_p0 <= 1'b0;
    end else if (clk_en && HazardStall) begin
      StallCycles <= satInc(StallCycles);
    end
  end

  // Output stage: replaced on advance even when the current entry issues this cycle
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      vld_p1       <= 1'b0;
      readA_p1     <= 1'b0;
      writeA_p1    <= 1'b0;
      markDirty_p1 <= 1'b0;
      readB_p1     <= 1'b0;
      aAddr_p1     <= '0;
      bAddr_p1     <= '0;
    end else if (advance) begin
      vld_p1       <= 1'b1;
      readA_p1     <= readA_p0;
      writeA_p1    <= writeA_p0;
      markDirty_p1 <= markDirty_p0;
      readB_p1     <= readB_p0;
      aAddr_p1     <= aAddr_p0;
      bAddr_p1     <= bAddr_p0;
    end else if (issueFire) begin
      vld_p1 <= 1'b0;
    end
  end

  assign IssueValid     = vld_p1;
  assign IssueReadA     = readA_p1;
  assign IssueWriteA    = writeA_p1;
  assign IssueMarkDirty = markDirty_p1;
  assign IssueReadB     = readB_p1;
  assign IssueAAddr     = aAddr_p1;
  assign IssueBAddr     = bAddr_p1;
  assign IssuedFromA    = issueFire && readA_p1;
  assign IssuedFromB    = issueFire && readB_p1;
  assign IssueAAddress  = aAddr_p1;
  assign IssueBAddress  = bAddr_p1;

endmodule
